mem_align_stage: RTL

MEM_ALIGN_STAGE -- requirements
Module: mem_align_stage

---
 rtl/mem_align_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_align_stage.sv
// Memory-access stage: accepts one load/store per handshake, checks alignment,
// runs a single data-memory transaction with an ack timeout, and presents the
// aligned/extended result to the MEM/WB register as a one-cycle out_valid pulse.
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE. dm_req is held high with stable command
// fields for the whole ACCESS state and completes on the edge where dm_ack is
// high; dm_ack seen outside ACCESS is ignored.
module mem_align_stage #(
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter bit          BYPASS_EN   = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_sdata,
  input  logic [4:0]  in_sreg,
  input  logic [4:0]  in_wreg,
  input  logic        in_wen,
  input  logic        fwd_wen,
  input  logic [4:0]  fwd_reg,
  input  logic [31:0] fwd_data,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        out_valid,
  output logic [4:0]  out_wreg,
  output logic        out_wen,
  output logic [31:0] out_data,
  output logic [1:0]  out_exc,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [4:0]    wreg_q, wreg_d;
  logic          wen_q, wen_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_wen_q, out_wen_d;
  logic [4:0]    out_wreg_q, out_wreg_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [1:0]    out_exc_q, out_exc_d;

  logic          in_is_load, in_is_store, in_misaligned, fwd_hit;
  logic          q_is_load, q_is_store;
  logic [1:0]    lane;
  logic          half_hi;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [3:0]    be_val;
  logic [31:0]   wdata_val;

  // Decode of the incoming op and forwarding match, used only at acceptance.
  always_comb begin
    in_is_load    = (in_op >= OP_LB) && (in_op <= OP_LW);
    in_is_store   = (in_op >= OP_SB) && (in_op <= OP_SW);
    in_misaligned = 1'b0;
    if ((in_op == OP_LH) || (in_op == OP_LHU) || (in_op == OP_SH))
      in_misaligned = in_addr[0];
    else if ((in_op == OP_LW) || (in_op == OP_SW))
      in_misaligned = (in_addr[1:0] != 2'b00);
    fwd_hit = BYPASS_EN && fwd_wen && (fwd_reg == in_sreg) && (fwd_reg != 5'd0);
  end

  // Lane selection, load extraction/extension and store replication for the held op.
  always_comb begin
    q_is_load  = (op_q >= OP_LB) && (op_q <= OP_LW);
    q_is_store = (op_q >= OP_SB) && (op_q <= OP_SW);
    // Byte offset -> physical lane; big-endian puts offset 0 in the top lane.
    lane       = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
    half_hi    = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
    ld_byte    = dm_rdata[{lane, 3'b000} +: 8];
    ld_half    = half_hi ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'h0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'h0, ld_half};
      default: ld_val = dm_rdata;
    endcase
    case (op_q)
      OP_LB, OP_LBU, OP_SB: be_val = 4'b0001 << lane;
      OP_LH, OP_LHU, OP_SH: be_val = half_hi ? 4'b1100 : 4'b0011;
      default:              be_val = 4'b1111;
    endcase
    case (op_q)
      OP_SB:   wdata_val = {4{sdata_q[7:0]}};
      OP_SH:   wdata_val = {2{sdata_q[15:0]}};
      default: wdata_val = sdata_q;
    endcase
  end

  // Next-state, op capture, ack timeout and MEM/WB register update.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wreg_d     = wreg_q;
    wen_d      = wen_q;
    cnt_d      = cnt_q;
    out_wen_d  = out_wen_q;
    out_wreg_d = out_wreg_q;
    out_data_d = out_data_q;
    out_exc_d  = out_exc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          addr_d  = in_addr;
          sdata_d = fwd_hit ? fwd_data : in_sdata;
          wreg_d  = in_wreg;
          wen_d   = in_wen;
          if (in_is_load || in_is_store) begin
            if (in_misaligned) begin
              state_d    = S_DONE;
              out_exc_d  = 2'd1;
              out_wen_d  = 1'b0;
              out_wreg_d = in_wreg;
              out_data_d = in_addr;
            end else begin
              state_d = S_ACCESS;
              cnt_d   = '0;
            end
          end else begin
            state_d    = S_DONE;
            out_exc_d  = 2'd0;
            out_wen_d  = in_wen;
            out_wreg_d = in_wreg;
            out_data_d = in_addr;
          end
        end
      end
      S_ACCESS: begin
        if (dm_ack) begin
          state_d    = S_DONE;
          out_exc_d  = 2'd0;
          out_wreg_d = wreg_q;
          out_wen_d  = q_is_load ? wen_q : 1'b0;
          out_data_d = q_is_load ? ld_val : addr_q;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d    = S_DONE;
          out_exc_d  = 2'd2;
          out_wreg_d = wreg_q;
          out_wen_d  = 1'b0;
          out_data_d = addr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 4'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      wreg_q     <= 5'd0;
      wen_q      <= 1'b0;
      cnt_q      <= '0;
      out_wen_q  <= 1'b0;
      out_wreg_q <= 5'd0;
      out_data_q <= 32'd0;
      out_exc_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wreg_q     <= wreg_d;
      wen_q      <= wen_d;
      cnt_q      <= cnt_d;
      out_wen_q  <= out_wen_d;
      out_wreg_q <= out_wreg_d;
      out_data_q <= out_data_d;
      out_exc_q  <= out_exc_d;
    end
  end

  // Bus command is live only in ACCESS; everything else is a registered view.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    dm_req    = (state_q == S_ACCESS);
    dm_we     = dm_req && q_is_store;
    dm_be     = dm_req ? be_val : 4'b0000;
    dm_addr   = {addr_q[31:2], 2'b00};
    dm_wdata  = wdata_val;
    out_valid = (state_q == S_DONE);
    out_wreg  = out_wreg_q;
    out_wen   = out_wen_q;
    out_data  = out_data_q;
    out_exc   = out_exc_q;
    dbg_state = state_q;
  end

endmodule
